// File: rtl/mem_loader.sv
// Boot-time program loader: assembles a byte stream into 32-bit words, writes each one to
// memory, verifies it by read-back, and holds the processor in reset until the image is loaded.
module mem_loader #(
    parameter int unsigned NWORDS    = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [31:0] word_count
);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e      state_q;
    logic [1:0]  byte_idx_q;
    logic [31:0] word_q;

    logic        accept;
    logic [31:0] next_word;
    logic [31:0] count_inc;
    logic        mismatch;

    assign accept    = byte_valid && byte_ready && (state_q == StCollect);
    // First byte of a word shifts up to the MSB, matching hex file order.
    assign next_word = {word_q[23:0], byte_data};
    assign count_inc = word_count + 32'd1;
    assign mismatch  = (mem_rd != word_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= BASE_ADDR;
            mem_wd     <= 32'd0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle, StError: begin
                    if (start) begin
                        state_q    <= StCollect;
                        byte_ready <= 1'b1;
                        error      <= 1'b0;
                        word_count <= 32'd0;
                        byte_idx_q <= 2'd0;
                        word_q     <= 32'd0;
                        mem_a      <= BASE_ADDR;
                    end
                end
                StCollect: begin
                    if (accept) begin
                        word_q <= next_word;
                        if (byte_idx_q == 2'd3) begin
                            byte_idx_q <= 2'd0;
                            state_q    <= StWrite;
                            mem_we     <= 1'b1;
                            mem_wd     <= next_word;
                            byte_ready <= 1'b0;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                StWrite: begin
                    mem_we  <= 1'b0;
                    state_q <= StCheck;
                end
                StCheck: begin
                    if (mismatch) begin
                        state_q <= StError;
                        error   <= 1'b1;
                    end else begin
                        word_count <= count_inc;
                        mem_a      <= mem_a + 32'd4;
                        if (count_inc == 32'(NWORDS)) begin
                            state_q   <= StDone;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state_q    <= StCollect;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    // Sticky until reset.
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected memory writes are queued by the stimulus and
// checked by an independent write monitor; status outputs are checked at directed points.
module tb_mem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [31:0] word_count;

    mem_loader #(
        .NWORDS   (2),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with an optional read-back fault on bit 0 at address 4.
    logic [31:0] mem [64];
    logic        fault;
    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    assign mem_rd = mem[mem_a[7:2]] ^ {31'd0, fault && (mem_a == 32'd4)};

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          n;
    } wr_t;
    wr_t sb[$];

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Write monitor: every mem_we cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", mem_a, e.a);
                check("wr_data", mem_wd, e.d);
                check("wr_bytes_accepted", 32'(acc_cnt), 32'(e.n));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start   = 1'b1;
        acc_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input int n);
        wr_t e;
        e.a = a;
        e.d = d;
        e.n = n;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n          = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            fail_now("byte_ready_wait");
        end else begin
            tick();
            acc_cnt++;
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 3; i >= 0; i--) send_byte(t[i*8 +: 8]);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail_now("wait_done_or_error");
    endtask

    initial begin
        fault     = 1'b0;
        byte_data = 8'h00;
        do_reset(2);

        // Reset values
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_word_count", word_count, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);

        // Back-to-back load of two words
        pulse_start();
        check("collect_byte_ready", 32'(byte_ready), 32'd1);
        expect_wr(32'd0, 32'hE340_0003, 4);
        expect_wr(32'd4, 32'hE340_1002, 8);
        send_word(32'hE340_0003);
        send_word(32'hE340_1002);
        wait_end();
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_cpu_reset", 32'(cpu_reset), 32'd0);
        check("b2b_word_count", word_count, 32'd2);
        check("b2b_error", 32'(error), 32'd0);

        // Done is sticky: start and offered bytes are ignored
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            check("sticky_byte_ready", 32'(byte_ready), 32'd0);
            check("sticky_done", 32'(done), 32'd1);
            check("sticky_cpu_reset", 32'(cpu_reset), 32'd0);
        end
        byte_valid = 1'b0;
        check("sticky_word_count", word_count, 32'd2);

        // Gapped stream: three idle cycles between bytes 2 and 3
        do_reset(1);
        pulse_start();
        expect_wr(32'd0, 32'hE340_0003, 4);
        send_byte(8'hE3);
        send_byte(8'h40);
        repeat (3) tick();
        send_byte(8'h00);
        send_byte(8'h03);
        repeat (3) tick();
        check("gap_word_count", word_count, 32'd1);
        check("gap_mem_a", mem_a, 32'd4);
        check("gap_byte_ready", 32'(byte_ready), 32'd1);
        check("gap_done", 32'(done), 32'd0);

        // Read-back fault on the second word, then restart
        do_reset(1);
        fault = 1'b1;
        pulse_start();
        expect_wr(32'd0, 32'hE340_0003, 4);
        expect_wr(32'd4, 32'hE340_1002, 8);
        send_word(32'hE340_0003);
        send_word(32'hE340_1002);
        wait_end();
        check("fault_error", 32'(error), 32'd1);
        check("fault_cpu_reset", 32'(cpu_reset), 32'd1);
        check("fault_word_count", word_count, 32'd1);
        check("fault_done", 32'(done), 32'd0);
        check("fault_byte_ready", 32'(byte_ready), 32'd0);
        fault = 1'b0;
        pulse_start();
        check("restart_mem_a", mem_a, 32'd0);
        check("restart_error", 32'(error), 32'd0);
        check("restart_word_count", word_count, 32'd0);
        check("restart_byte_ready", 32'(byte_ready), 32'd1);
        expect_wr(32'd0, 32'h1234_5678, 4);
        expect_wr(32'd4, 32'h9ABC_DEF0, 8);
        send_word(32'h1234_5678);
        send_word(32'h9ABC_DEF0);
        wait_end();
        check("restart_done", 32'(done), 32'd1);
        check("restart_final_count", word_count, 32'd2);

        // Reset mid-word discards the partial word
        do_reset(1);
        pulse_start();
        send_byte(8'hDE);
        send_byte(8'hAD);
        do_reset(1);
        check("midrst_byte_ready", 32'(byte_ready), 32'd0);
        check("midrst_mem_a", mem_a, 32'd0);
        pulse_start();
        expect_wr(32'd0, 32'h1122_3344, 4);
        send_word(32'h1122_3344);
        repeat (3) tick();
        check("midrst_word_count", word_count, 32'd1);
        check("midrst_mem_a_next", mem_a, 32'd4);

        repeat (2) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
